// File: rtl/ex_lsu_xlate.sv
// ex_lsu_xlate: EX-stage load/store unit. Forms the effective VA, translates it through
// direct-map windows or a fixed-latency TLB port, flags ALE/TLB faults and issues the SRAM request.
module ex_lsu_xlate #(
    parameter int NUM_DMW = 2,
    parameter int TLB_LAT = 1,
    parameter int HUGE_PS = 21
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_allowin,
    input  logic                 in_ld,
    input  logic                 in_st,
    input  logic [1:0]           in_size,
    input  logic [31:0]          in_base,
    input  logic [31:0]          in_offset,
    input  logic [31:0]          in_wdata,
    input  logic                 csr_pg,
    input  logic [1:0]           csr_plv,
    input  logic [3*NUM_DMW-1:0] dmw_vseg,
    input  logic [3*NUM_DMW-1:0] dmw_pseg,
    input  logic [NUM_DMW-1:0]   dmw_plv_met,
    output logic [18:0]          tlb_vppn,
    output logic                 tlb_va12,
    input  logic                 tlb_found,
    input  logic                 tlb_v,
    input  logic                 tlb_d,
    input  logic [19:0]          tlb_ppn,
    input  logic [5:0]           tlb_ps,
    input  logic [1:0]           tlb_plv,
    output logic                 req,
    output logic                 wr,
    output logic [1:0]           size,
    output logic [3:0]           wstrb,
    output logic [31:0]          wdata,
    output logic [31:0]          addr,
    input  logic                 addr_ok,
    output logic                 out_valid,
    input  logic                 out_allowin,
    output logic                 out_excep,
    output logic [5:0]           out_ecode,
    output logic [31:0]          out_badv,
    output logic                 out_discard,
    input  logic                 flush
);

    typedef enum logic [1:0] {S_IDLE, S_XLATE, S_REQ, S_DONE} state_t;

    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_PME  = 6'h04;

    state_t      state_q, state_d;
    logic [31:0] va_q;
    logic        ld_q, st_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt_q;
    logic [31:0] addr_q;
    logic        excep_q;
    logic [5:0]  ecode_q;
    logic        discard_pend_q;

    logic        accept;
    logic        dmw_hit;
    logic [31:0] dmw_pa;
    logic        ale, tlb_chk, need_wait, xlate_done;
    logic [31:0] pa_next;
    logic        exc_next;
    logic [5:0]  ecode_next;

    assign in_allowin = (state_q == S_IDLE) || (state_q == S_DONE && out_allowin);
    // A flush cycle never admits a new op, even if ID presents one.
    assign accept     = in_valid && in_allowin && !flush;

    assign tlb_vppn = va_q[31:13];
    assign tlb_va12 = va_q[12];

    // NOTE: combinational blocks use blocking '=' and give every output a default first,
    // so each path assigns it and no latch is inferred.
    always_comb begin
        dmw_hit = 1'b0;
        dmw_pa  = '0;
        for (int i = 0; i < NUM_DMW; i++) begin
            if (!dmw_hit && dmw_plv_met[i] && dmw_vseg[3*i +: 3] == va_q[31:29]) begin
                dmw_hit = 1'b1;
                dmw_pa  = {dmw_pseg[3*i +: 3], va_q[28:0]};
            end
        end
    end

    assign ale        = (size_q == 2'd1 && va_q[0]) || (size_q[1] && va_q[1:0] != 2'b00);
    assign tlb_chk    = csr_pg && !dmw_hit;
    assign need_wait  = tlb_chk && !ale;
    assign xlate_done = !need_wait || (cnt_q == 2'(TLB_LAT));

    always_comb begin
        pa_next = va_q;
        if (csr_pg) begin
            if (dmw_hit)
                pa_next = dmw_pa;
            else if (tlb_ps == 6'(HUGE_PS))
                pa_next = {tlb_ppn[19:9], va_q[20:0]};
            else
                pa_next = {tlb_ppn, va_q[11:0]};
        end
    end

    always_comb begin
        exc_next   = 1'b1;
        ecode_next = 6'h00;
        if (ale)                             ecode_next = ECODE_ALE;
        else if (tlb_chk && !tlb_found)      ecode_next = ECODE_TLBR;
        else if (tlb_chk && ld_q && !tlb_v)  ecode_next = ECODE_PIL;
        else if (tlb_chk && st_q && !tlb_v)  ecode_next = ECODE_PIS;
        else if (tlb_chk && tlb_plv < csr_plv) ecode_next = ECODE_PPI;
        else if (tlb_chk && st_q && !tlb_d)  ecode_next = ECODE_PME;
        else                                 exc_next   = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        req       = (state_q == S_REQ);
        out_valid = (state_q == S_DONE);
        out_excep = (state_q == S_DONE) && excep_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_XLATE;
            S_XLATE: begin
                if (flush)           state_d = S_IDLE;
                else if (xlate_done) state_d = exc_next ? S_DONE : S_REQ;
            end
            // A request once raised is never withdrawn; a flush only turns its completion into a discard.
            S_REQ:   if (addr_ok) state_d = (discard_pend_q || flush) ? S_IDLE : S_DONE;
            S_DONE: begin
                if (flush)            state_d = S_IDLE;
                else if (out_allowin) state_d = accept ? S_XLATE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            va_q           <= '0;
            ld_q           <= 1'b0;
            st_q           <= 1'b0;
            size_q         <= '0;
            wdata_q        <= '0;
            cnt_q          <= '0;
            addr_q         <= '0;
            excep_q        <= 1'b0;
            ecode_q        <= '0;
            discard_pend_q <= 1'b0;
            out_discard    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_discard <= (state_q == S_REQ) && addr_ok && (discard_pend_q || flush);
            if (accept) begin
                va_q    <= in_base + in_offset;
                ld_q    <= in_ld;
                st_q    <= in_st;
                size_q  <= in_size;
                wdata_q <= in_wdata;
                cnt_q   <= '0;
            end
            if (state_q == S_XLATE) begin
                if (!xlate_done) begin
                    cnt_q <= cnt_q + 2'd1;
                end else begin
                    addr_q  <= pa_next;
                    excep_q <= exc_next;
                    ecode_q <= ecode_next;
                end
            end
            if (state_q == S_REQ) begin
                if (addr_ok)    discard_pend_q <= 1'b0;
                else if (flush) discard_pend_q <= 1'b1;
            end
        end
    end

    assign wr        = st_q;
    assign size      = size_q;
    assign addr      = addr_q;
    assign out_ecode = ecode_q;
    assign out_badv  = va_q;

    always_comb begin
        wstrb = 4'b0000;
        wdata = wdata_q;
        case (size_q)
            2'd0: begin
                wdata = {4{wdata_q[7:0]}};
                wstrb = 4'b0001 << addr_q[1:0];
            end
            2'd1: begin
                wdata = {2{wdata_q[15:0]}};
                wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: wstrb = 4'b1111;
        endcase
        if (!st_q) wstrb = 4'b0000;
    end

endmodule

// File: tb/tb_ex_lsu_xlate.sv
// Self-checking bench for ex_lsu_xlate: directed scenarios plus randomized ops against a
// behavioural translation/exception/timing model and a one-cycle registered TLB responder.
module tb_ex_lsu_xlate;

    localparam int NUM_DMW = 2;
    localparam int TLB_LAT = 1;
    localparam int HUGE_PS = 21;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic in_valid = 1'b0, in_allowin, in_ld = 1'b0, in_st = 1'b0;
    logic [1:0] in_size = '0;
    logic [31:0] in_base = '0, in_offset = '0, in_wdata = '0;
    logic [3*NUM_DMW-1:0] dmw_vseg, dmw_pseg;
    logic [NUM_DMW-1:0] dmw_plv_met;
    logic [18:0] tlb_vppn;
    logic tlb_va12, tlb_found, tlb_v, tlb_d;
    logic [19:0] tlb_ppn;
    logic [5:0] tlb_ps;
    logic [1:0] tlb_plv;
    logic req, wr;
    logic [1:0] size;
    logic [3:0] wstrb;
    logic [31:0] wdata, addr;
    logic addr_ok = 1'b0, out_valid, out_allowin = 1'b1, out_excep;
    logic [5:0] out_ecode;
    logic [31:0] out_badv;
    logic out_discard, flush = 1'b0;

    // Environment configuration: CSRs, windows and the single TLB entry the responder knows.
    logic        cfg_pg = 1'b0;
    logic [1:0]  cfg_plv = 2'd0;
    logic [2:0]  cfg_vseg [NUM_DMW];
    logic [2:0]  cfg_pseg [NUM_DMW];
    logic        cfg_met  [NUM_DMW];
    logic [18:0] t_vppn = '0;
    logic        t_found = 1'b0, t_v = 1'b0, t_d = 1'b0;
    logic [19:0] t_ppn = '0;
    logic [5:0]  t_ps = 6'd12;
    logic [1:0]  t_plv = 2'd0;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        dmw_vseg = '0;
        dmw_pseg = '0;
        dmw_plv_met = '0;
        for (int i = 0; i < NUM_DMW; i++) begin
            dmw_vseg[3*i +: 3] = cfg_vseg[i];
            dmw_pseg[3*i +: 3] = cfg_pseg[i];
            dmw_plv_met[i]     = cfg_met[i];
        end
    end

    always_ff @(posedge clk) begin
        tlb_found <= t_found && (tlb_vppn == t_vppn);
        tlb_v     <= t_v;
        tlb_d     <= t_d;
        tlb_ppn   <= t_ppn;
        tlb_ps    <= t_ps;
        tlb_plv   <= t_plv;
    end

    ex_lsu_xlate #(.NUM_DMW(NUM_DMW), .TLB_LAT(TLB_LAT), .HUGE_PS(HUGE_PS)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_ld(in_ld), .in_st(in_st),
        .in_size(in_size), .in_base(in_base), .in_offset(in_offset), .in_wdata(in_wdata),
        .csr_pg(cfg_pg), .csr_plv(cfg_plv),
        .dmw_vseg(dmw_vseg), .dmw_pseg(dmw_pseg), .dmw_plv_met(dmw_plv_met),
        .tlb_vppn(tlb_vppn), .tlb_va12(tlb_va12), .tlb_found(tlb_found), .tlb_v(tlb_v),
        .tlb_d(tlb_d), .tlb_ppn(tlb_ppn), .tlb_ps(tlb_ps), .tlb_plv(tlb_plv),
        .req(req), .wr(wr), .size(size), .wstrb(wstrb), .wdata(wdata), .addr(addr),
        .addr_ok(addr_ok), .out_valid(out_valid), .out_allowin(out_allowin),
        .out_excep(out_excep), .out_ecode(out_ecode), .out_badv(out_badv),
        .out_discard(out_discard), .flush(flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: outcome of one op from the translation and exception rules.
    function automatic void model(input logic ld, input logic [1:0] sz, input logic [31:0] va,
                                  output logic exc, output logic [5:0] ec,
                                  output logic [31:0] pa, output int wt);
        int  hit = -1;
        logic found;
        exc = 1'b0; ec = 6'h00; pa = va; wt = 0;
        if ((sz == 2'd1 && va % 2 != 0) || (sz == 2'd2 && va % 4 != 0)) begin
            exc = 1'b1; ec = 6'h09;
            return;
        end
        if (!cfg_pg) return;
        for (int i = NUM_DMW - 1; i >= 0; i--)
            if (cfg_met[i] && cfg_vseg[i] == 3'(va >> 29)) hit = i;
        if (hit >= 0) begin
            pa = (32'(cfg_pseg[hit]) << 29) + (va % 32'h2000_0000);
            return;
        end
        wt = TLB_LAT;
        found = t_found && (t_vppn == 19'(va >> 13));
        exc = 1'b1;
        if (!found)              ec = 6'h3F;
        else if (ld && !t_v)     ec = 6'h01;
        else if (!ld && !t_v)    ec = 6'h02;
        else if (t_plv < cfg_plv) ec = 6'h07;
        else if (!ld && !t_d)    ec = 6'h04;
        else                     exc = 1'b0;
        if (t_ps == 6'(HUGE_PS)) pa = ((32'(t_ppn) >> 9) << 21) + (va % 32'h0020_0000);
        else                     pa = (32'(t_ppn) << 12) + (va % 32'h0000_1000);
    endfunction

    // Presents one op at the next negedge; returns one cycle later with in_valid dropped.
    task automatic start_op(input logic ld, input logic [1:0] sz, input logic [31:0] base,
                            input logic [31:0] off, input logic [31:0] wd);
        @(negedge clk);
        check("accept_ready", in_allowin, 1);
        in_valid = 1'b1; in_ld = ld; in_st = !ld; in_size = sz;
        in_base = base; in_offset = off; in_wdata = wd;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Full op: addr_ok given in the (ok_delay+1)-th request cycle; everything compared to the model.
    task automatic issue(input logic ld, input logic [1:0] sz, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd, input int ok_delay);
        logic        exc;
        logic [5:0]  ec;
        logic [31:0] pa, va, exp_wd;
        logic [3:0]  exp_strb;
        int          wt, exp_done, cyc, reqc;
        va = base + off;
        model(ld, sz, va, exc, ec, pa, wt);
        exp_done = exc ? 2 + wt : 3 + wt + ok_delay;
        case (sz)
            2'd0:    begin exp_wd = 32'(wd[7:0]) * 32'h0101_0101; exp_strb = 4'(1 << (pa % 4)); end
            2'd1:    begin exp_wd = 32'(wd[15:0]) * 32'h0001_0001; exp_strb = (pa % 4 >= 2) ? 4'hC : 4'h3; end
            default: begin exp_wd = wd; exp_strb = 4'hF; end
        endcase
        if (ld) exp_strb = 4'h0;
        start_op(ld, sz, base, off, wd);
        cyc = 1; reqc = 0;
        while (!out_valid && cyc < 40) begin
            if (req) begin
                check("req_addr", addr, pa);
                if (reqc == 0) begin
                    check("req_wstrb", 32'(wstrb), 32'(exp_strb));
                    check("req_wr", 32'(wr), 32'(!ld));
                    check("req_size", 32'(size), 32'(sz));
                    if (!ld) check("req_wdata", wdata, exp_wd);
                end
                addr_ok = (reqc == ok_delay);
                reqc++;
            end else begin
                addr_ok = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        addr_ok = 1'b0;
        check("done_cycle", cyc, exp_done);
        check("req_cycles", reqc, exc ? 0 : ok_delay + 1);
        check("out_excep", 32'(out_excep), 32'(exc));
        if (exc) begin
            check("out_ecode", 32'(out_ecode), 32'(ec));
            check("out_badv", out_badv, va);
        end
        if (!out_valid) begin
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(out_valid), 1);
    endtask

    initial begin
        int acc, ov, rq;
        logic [31:0] base, off;
        for (int i = 0; i < NUM_DMW; i++) begin
            cfg_vseg[i] = 3'd0; cfg_pseg[i] = 3'd0; cfg_met[i] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", 32'(req), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_excep", 32'(out_excep), 0);
        check("rst_out_discard", 32'(out_discard), 0);
        check("rst_in_allowin", 32'(in_allowin), 1);
        check("rst_addr", addr, 0);
        resetn = 1'b1;

        // Unmapped ld.w: PA=VA, out_valid third cycle after accept
        issue(1'b1, 2'd2, 32'h0000_1000, 32'd4, 32'h0, 0);

        // DMW1 hit, st.b
        cfg_pg = 1'b1; cfg_plv = 2'd3;
        cfg_vseg[0] = 3'd1; cfg_pseg[0] = 3'd7; cfg_met[0] = 1'b1;
        cfg_vseg[1] = 3'd5; cfg_pseg[1] = 3'd0; cfg_met[1] = 1'b1;
        issue(1'b0, 2'd0, 32'hA000_0000, 32'd3, 32'h0000_00A5, 1);

        // Both windows match: lowest index wins
        cfg_vseg[0] = 3'd4; cfg_pseg[0] = 3'd1; cfg_vseg[1] = 3'd4; cfg_pseg[1] = 3'd2;
        issue(1'b0, 2'd1, 32'h8000_1000, 32'h0000_0002, 32'h1234_BEEF, 0);

        // TLB hit, dirty clear on store -> PME
        cfg_met[0] = 1'b0; cfg_met[1] = 1'b0;
        t_vppn = 19'h12345 >> 1; t_found = 1'b1; t_v = 1'b1; t_d = 1'b0; t_plv = 2'd3;
        t_ppn = 20'hABCDE; t_ps = 6'd12;
        issue(1'b0, 2'd2, {t_vppn, 13'h0}, 32'h0000_0010, 32'hDEAD_BEEF, 0);

        // Misaligned ld.h -> ALE; TLB miss on aligned ld -> TLBR
        issue(1'b1, 2'd1, 32'h0040_0000, 32'd1, 32'h0, 0);
        t_found = 1'b0;
        issue(1'b1, 2'd2, {t_vppn, 13'h0}, 32'd8, 32'h0, 0);

        // Huge page load hit
        t_found = 1'b1; t_d = 1'b1; t_ps = 6'(HUGE_PS);
        issue(1'b1, 2'd2, {t_vppn, 13'h0}, 32'h0000_0104, 32'h0, 2);

        // Flush in REQ, addr_ok in third request cycle -> discard, no out_valid
        cfg_pg = 1'b0;
        start_op(1'b0, 2'd2, 32'h0000_3000, 32'd0, 32'h5555_AAAA);
        @(negedge clk);
        flush = 1'b1;
        rq = 0;
        for (int i = 0; i < 3; i++) begin
            if (req) rq++;
            check("flush_req_no_valid", 32'(out_valid), 0);
            addr_ok = (i == 2);
            @(negedge clk);
            flush = 1'b0;
        end
        addr_ok = 1'b0;
        check("flush_req_cycles", rq, 3);
        check("flush_req_dropped", 32'(req), 0);
        check("flush_discard_pulse", 32'(out_discard), 1);
        check("flush_discard_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("flush_discard_end", 32'(out_discard), 0);
        check("flush_discard_idle", 32'(in_allowin), 1);

        // Flush coinciding with addr_ok
        start_op(1'b1, 2'd2, 32'h0000_3004, 32'd0, 32'h0);
        @(negedge clk);
        check("flush_ok_req", 32'(req), 1);
        flush = 1'b1; addr_ok = 1'b1;
        @(negedge clk);
        flush = 1'b0; addr_ok = 1'b0;
        check("flush_ok_discard", 32'(out_discard), 1);
        check("flush_ok_valid", 32'(out_valid), 0);
        check("flush_ok_idle", 32'(in_allowin), 1);

        // Flush during TLB wait in XLATE
        cfg_pg = 1'b1;
        start_op(1'b1, 2'd2, {t_vppn, 13'h0}, 32'd0, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        rq = 0; ov = 0;
        for (int i = 0; i < 4; i++) begin
            if (req) rq++;
            if (out_valid) ov++;
            @(negedge clk);
        end
        check("flush_xlate_req", rq, 0);
        check("flush_xlate_valid", ov, 0);

        // Flush in DONE while MEM stalls; in_valid ignored during flush in IDLE
        cfg_pg = 1'b0; out_allowin = 1'b0; addr_ok = 1'b1;
        start_op(1'b1, 2'd2, 32'h0000_4000, 32'd0, 32'h0);
        wait_valid("done_reached");
        addr_ok = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_done_valid", 32'(out_valid), 0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_allowin = 1'b1;
        check("flush_ignores_in_valid", 32'(in_allowin), 1);

        // Async reset in the middle of a request
        start_op(1'b0, 2'd2, 32'h0000_5000, 32'd0, 32'h0);
        @(negedge clk);
        check("pre_reset_req", 32'(req), 1);
        #2 resetn = 1'b0;
        #1 check("async_reset_req", 32'(req), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Back-to-back: in_valid held, one accept per DONE cycle
        addr_ok = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_ld = 1'b1; in_st = 1'b0; in_size = 2'd2;
        in_base = 32'h0000_6000; in_offset = 32'd0;
        acc = 0; ov = 0;
        for (int i = 0; i < 13; i++) begin
            check("b2b_allowin", 32'(in_allowin), 32'(i % 3 == 0));
            check("b2b_valid", 32'(out_valid), 32'(i > 0 && i % 3 == 0));
            if (in_allowin) acc++;
            if (out_valid) ov++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_accepts", acc, 5);
        check("b2b_completions", ov, 4);
        wait_valid("b2b_drain");
        addr_ok = 1'b0;

        // Randomized ops against the model
        for (int n = 0; n < 60; n++) begin
            logic ld;
            logic [1:0] sz;
            logic [31:0] va;
            cfg_pg  = ($urandom_range(0, 3) != 0);
            cfg_plv = 2'($urandom_range(0, 3));
            for (int i = 0; i < NUM_DMW; i++) begin
                cfg_vseg[i] = 3'($urandom_range(0, 7));
                cfg_pseg[i] = 3'($urandom_range(0, 7));
                cfg_met[i]  = 1'($urandom_range(0, 1));
            end
            ld   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 2));
            base = $urandom;
            if ($urandom_range(0, 3) != 0) base[1:0] = 2'b00;
            off  = 32'($urandom_range(0, 15)) * 32'd4 - 32'd32;
            va   = base + off;
            if ($urandom_range(0, 2) == 0) cfg_vseg[$urandom_range(0, NUM_DMW - 1)] = va[31:29];
            t_vppn  = ($urandom_range(0, 3) != 0) ? va[31:13] : 19'($urandom);
            t_found = ($urandom_range(0, 5) != 0);
            t_v     = ($urandom_range(0, 5) != 0);
            t_d     = ($urandom_range(0, 4) != 0);
            t_plv   = ($urandom_range(0, 2) != 0) ? 2'd3 : 2'($urandom_range(0, 3));
            t_ps    = $urandom_range(0, 1) ? 6'(HUGE_PS) : 6'd12;
            t_ppn   = 20'($urandom);
            issue(ld, sz, base, off, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
